// File: rtl/instruction_prefetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_prefetch_buffer_pkg
// Purpose  : Shared global definitions for the instruction fetch path.
//            - Machine word widths (instruction word and address/data word).
//            - Encodings of the prefetch request FSM states.
//            - A word-alignment helper for fetch addresses.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_prefetch_buffer_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int DATA_WIDTH        = 32;

  // Byte distance between consecutive instruction words
  localparam int PC_STEP = 4;

  // Prefetch request FSM
  //   IDLE    : no request outstanding (buffer full)
  //   REQ     : request outstanding; its data will be enqueued
  //   DISCARD : request outstanding; its data belongs to a stale path
  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_REQ     = 2'd1,
    STATE_DISCARD = 2'd2
  } fetchState_t;

  // Clear the byte-offset bits so every fetch address is word aligned
  function automatic logic [DATA_WIDTH-1:0] alignWord(input logic [DATA_WIDTH-1:0] addr);
    return addr & ~DATA_WIDTH'(3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_prefetch_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with wrapping pointers and an occupancy count.
//            Flush empties the FIFO in one cycle and wins over push/pop.
//            The head entry is presented combinationally (no output register).
// Ports    : clk, reset    - clock, synchronous active-high reset
//            push/pushData - write pushData at the tail (ignored when full)
//            pop           - remove the head (ignored when empty)
//            flush         - discard all entries
//            full, empty   - occupancy flags
//            count         - number of stored entries (0..DEPTH)
//            headData      - contents of the head entry
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,            // power of two, 2..16
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] headData
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_doPush;
  logic w_doPop;

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign headData = r_mem[r_rdPtr];

  // Guards make overflow and underflow impossible regardless of the caller
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
    end
  end

  // Storage is not reset; it is only visible through a non-zero count
  always_ff @(posedge clk) begin
    if (w_doPush && !flush) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_prefetch_buffer
// Purpose  : Prefetches sequential instruction words from instruction memory
//            into a small FIFO ahead of the fetch controller. A redirect
//            (taken branch/jump) flushes the FIFO and restarts fetching at
//            the new address; data of a request already in flight on the
//            old path is dropped.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            redirect, redirectPc  - taken branch/jump and its target
//            mem_req, mem_addr     - instruction memory read request/address
//            mem_ack, mem_rdata    - request accepted, read data same cycle
//            inst_valid, inst_out, - FIFO head instruction and its address
//            inst_pc
//            inst_ready            - consumer takes the head this cycle
// Revision : 1.0 - initial release
// ============================================================================
module instruction_prefetch_buffer
  import instruction_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4              // power of two, 2..16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [DATA_WIDTH-1:0]        redirectPc,
  output logic                         mem_req,
  output logic [DATA_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
  output logic                         inst_valid,
  output logic [INSTRUCTION_WIDTH-1:0] inst_out,
  output logic [DATA_WIDTH-1:0]        inst_pc,
  input  logic                         inst_ready
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INSTRUCTION_WIDTH + DATA_WIDTH;

  fetchState_t           r_state;
  logic [DATA_WIDTH-1:0] r_fetchPc;
  logic [DATA_WIDTH-1:0] r_pendPc;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_nextCount;
  logic [ENTRY_W-1:0]    w_head;
  logic [DATA_WIDTH-1:0] w_alignedRedirect;

  assign w_alignedRedirect = alignWord(redirectPc);

  // Only an ack in REQ on the current path produces a FIFO entry
  assign w_push  = (r_state == STATE_REQ) && mem_ack && !redirect && !w_full;
  assign w_pop   = inst_valid && inst_ready;
  assign w_flush = redirect;

  // Occupancy after an enqueue this cycle; only consulted in REQ, where the
  // count is always below DEPTH, so the increment cannot overflow
  assign w_nextCount = w_count + CNT_W'(1) - CNT_W'(w_pop);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .pushData ({mem_rdata, r_fetchPc}),
    .pop      (w_pop),
    .flush    (w_flush),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count),
    .headData (w_head)
  );

  // Request FSM and fetch address tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= STATE_IDLE;
      r_fetchPc <= '0;
      r_pendPc  <= '0;
    end else begin
      case (r_state)
        STATE_IDLE: begin
          if (redirect) begin
            r_fetchPc <= w_alignedRedirect;
            r_state   <= STATE_REQ;
          end else if (w_count < CNT_W'(DEPTH)) begin
            r_state   <= STATE_REQ;
          end
        end

        STATE_REQ: begin
          if (redirect && mem_ack) begin
            // The in-flight request completes now, so restart directly
            r_fetchPc <= w_alignedRedirect;
          end else if (redirect) begin
            // The old request stays on the bus (address must stay stable);
            // remember the target until its ack arrives
            r_pendPc  <= w_alignedRedirect;
            r_state   <= STATE_DISCARD;
          end else if (mem_ack) begin
            r_fetchPc <= r_fetchPc + DATA_WIDTH'(PC_STEP);
            if (w_nextCount >= CNT_W'(DEPTH)) begin
              r_state <= STATE_IDLE;
            end
          end
        end

        STATE_DISCARD: begin
          if (mem_ack) begin
            // A redirect coinciding with the ack is the most recent target
            r_fetchPc <= redirect ? w_alignedRedirect : r_pendPc;
            r_state   <= STATE_REQ;
          end else if (redirect) begin
            r_pendPc  <= w_alignedRedirect;
          end
        end

        default: r_state <= STATE_IDLE;
      endcase
    end
  end

  // Reset forces every output to zero even before the first reset edge
  assign mem_req    = !reset && (r_state != STATE_IDLE);
  assign mem_addr   = reset ? '0 : r_fetchPc;
  assign inst_valid = !reset && !w_empty;

  // Storage is not reset, so the head is masked while the FIFO is empty
  assign inst_out = inst_valid ? w_head[ENTRY_W-1 -: INSTRUCTION_WIDTH] : '0;
  assign inst_pc  = inst_valid ? w_head[DATA_WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_prefetch_buffer
// Purpose  : Directed self-checking bench for instruction_prefetch_buffer.
//            Memory read data is a fixed function of the address so every
//            instruction word can be predicted from its PC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_prefetch_buffer;
  import instruction_prefetch_buffer_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         redirect;
  logic [DATA_WIDTH-1:0]        redirectPc;
  logic                         mem_req;
  logic [DATA_WIDTH-1:0]        mem_addr;
  logic                         mem_ack;
  logic [INSTRUCTION_WIDTH-1:0] mem_rdata;
  logic                         inst_valid;
  logic [INSTRUCTION_WIDTH-1:0] inst_out;
  logic [DATA_WIDTH-1:0]        inst_pc;
  logic                         inst_ready;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: word at address A is 0xC0DE0000 ^ A
  assign mem_rdata = 32'hC0DE_0000 ^ mem_addr;

  function automatic logic [31:0] instAt(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  instruction_prefetch_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  // One clock edge; outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles and release; leaves the DUT one edge past reset
  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirectPc = '0;
    mem_ack = 1'b0; inst_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b1; redirectPc = 32'h40; mem_ack = 1'b1; inst_ready = 1'b1;
    step(); step();
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    nChecks++; if (mem_addr !== 32'h0) begin nFails++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    nChecks++; if (inst_valid !== 1'b0) begin nFails++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
    nChecks++; if (inst_out !== 32'h0) begin nFails++; $display("FAIL reset_inst_out got=%h exp=0", inst_out); end
    nChecks++; if (inst_pc !== 32'h0) begin nFails++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
    nChecks++; if (dut.w_count !== 3'd0) begin nFails++; $display("FAIL reset_count got=%0d exp=0", dut.w_count); end
    reset = 1'b0; redirect = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    // Released reset: state is IDLE, one edge later a request to 0 appears
    nChecks++; if (dut.r_state !== STATE_IDLE) begin nFails++; $display("FAIL reset_state_idle got=%0d exp=%0d", dut.r_state, STATE_IDLE); end
    step();
    nChecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin nFails++; $display("FAIL reset_first_req got=%b/%h exp=1/00000000", mem_req, mem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nChecks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin nFails++; $display("FAIL stream_addr[%0d] got=%b/%h exp=1/%h", i, mem_req, mem_addr, 32'(4 * i)); end
      step();
      nChecks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i)) begin nFails++; $display("FAIL stream_pc[%0d] got=%b/%h exp=1/%h", i, inst_valid, inst_pc, 32'(4 * i)); end
      nChecks++; if (inst_out !== instAt(32'(4 * i))) begin nFails++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, inst_out, instAt(32'(4 * i))); end
    end
    mem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_full();
    bit seen;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    step(); step(); step(); step();
    nChecks++; if (dut.w_count !== 3'd4) begin nFails++; $display("FAIL full_count got=%0d exp=4", dut.w_count); end
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("FAIL full_mem_req got=%b exp=0", mem_req); end
    nChecks++; if (dut.r_state !== STATE_IDLE) begin nFails++; $display("FAIL full_state got=%0d exp=%0d", dut.r_state, STATE_IDLE); end
    nChecks++; if (inst_pc !== 32'h0 || inst_out !== instAt(32'h0)) begin nFails++; $display("FAIL full_head got=%h/%h exp=00000000/%h", inst_pc, inst_out, instAt(32'h0)); end
    inst_ready = 1'b1; mem_ack = 1'b0;
    step();
    inst_ready = 1'b0;
    nChecks++; if (dut.w_count !== 3'd3 || inst_pc !== 32'h4) begin nFails++; $display("FAIL full_after_pop got=%0d/%h exp=3/00000004", dut.w_count, inst_pc); end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (mem_req === 1'b1) seen = 1'b1;
      else step();
    end
    nChecks++; if (!seen || mem_addr !== 32'h10) begin nFails++; $display("FAIL full_rerequest got=%b/%h exp=1/00000010", seen, mem_addr); end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    mem_ack = 1'b0; inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nChecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin nFails++; $display("FAIL delay_hold[%0d] got=%b/%h exp=1/00000000", i, mem_req, mem_addr); end
      step();
      nChecks++; if (inst_valid !== 1'b0) begin nFails++; $display("FAIL delay_no_enq[%0d] got=%b exp=0", i, inst_valid); end
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    nChecks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== instAt(32'h0)) begin nFails++; $display("FAIL delay_enq got=%b/%h/%h exp=1/00000000/%h", inst_valid, inst_pc, inst_out, instAt(32'h0)); end
    nChecks++; if (mem_addr !== 32'h4) begin nFails++; $display("FAIL delay_next_addr got=%h exp=00000004", mem_addr); end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    step();
    mem_ack = 1'b0; redirect = 1'b1; redirectPc = 32'h103;
    step();
    redirect = 1'b0;
    nChecks++; if (inst_valid !== 1'b0) begin nFails++; $display("FAIL disc_flush got=%b exp=0", inst_valid); end
    nChecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin nFails++; $display("FAIL disc_hold got=%b/%h exp=1/00000004", mem_req, mem_addr); end
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    nChecks++; if (inst_valid !== 1'b0 || dut.w_count !== 3'd0) begin nFails++; $display("FAIL disc_dropped got=%b/%0d exp=0/0", inst_valid, dut.w_count); end
    nChecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin nFails++; $display("FAIL disc_new_addr got=%b/%h exp=1/00000100", mem_req, mem_addr); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    nChecks++; if (inst_pc !== 32'h100 || inst_out !== instAt(32'h100)) begin nFails++; $display("FAIL disc_first_new got=%h/%h exp=00000100/%h", inst_pc, inst_out, instAt(32'h100)); end
  endtask

  task automatic test_redirect_ack_dequeue();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    step(); step();
    nChecks++; if (dut.w_count !== 3'd2) begin nFails++; $display("FAIL rad_pre_count got=%0d exp=2", dut.w_count); end
    redirect = 1'b1; redirectPc = 32'h200; mem_ack = 1'b1; inst_ready = 1'b1;
    nChecks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin nFails++; $display("FAIL rad_dequeue_head got=%b/%h exp=1/00000000", inst_valid, inst_pc); end
    step();
    redirect = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    nChecks++; if (dut.w_count !== 3'd0 || inst_valid !== 1'b0) begin nFails++; $display("FAIL rad_count got=%0d/%b exp=0/0", dut.w_count, inst_valid); end
    nChecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin nFails++; $display("FAIL rad_addr got=%b/%h exp=1/00000200", mem_req, mem_addr); end
  endtask

  task automatic test_reset_in_discard();
    do_reset();
    mem_ack = 1'b0; redirect = 1'b1; redirectPc = 32'h300;
    step();
    redirectPc = 32'h407;
    step();
    nChecks++; if (dut.r_state !== STATE_DISCARD || mem_addr !== 32'h0) begin nFails++; $display("FAIL rid_discard got=%0d/%h exp=%0d/00000000", dut.r_state, mem_addr, STATE_DISCARD); end
    redirect = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    nChecks++; if (mem_addr !== 32'h404) begin nFails++; $display("FAIL rid_pend_overwrite got=%h exp=00000404", mem_addr); end
    redirect = 1'b1; redirectPc = 32'h500;
    step();
    reset = 1'b1; mem_ack = 1'b1; redirect = 1'b1; redirectPc = 32'h600;
    step();
    reset = 1'b0; mem_ack = 1'b0; redirect = 1'b0;
    nChecks++; if (dut.r_state !== STATE_IDLE || dut.w_count !== 3'd0 || dut.r_fetchPc !== 32'h0) begin nFails++; $display("FAIL rid_after_reset got=%0d/%0d/%h exp=%0d/0/00000000", dut.r_state, dut.w_count, dut.r_fetchPc, STATE_IDLE); end
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("FAIL rid_idle_req got=%b exp=0", mem_req); end
    step();
    nChecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin nFails++; $display("FAIL rid_req0 got=%b/%h exp=1/00000000", mem_req, mem_addr); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    mem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b1; redirectPc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0; mem_ack = 1'b1;
    step();
    nChecks++; if (mem_addr !== 32'hFFFF_FFFC) begin nFails++; $display("FAIL wrap_start got=%h exp=fffffffc", mem_addr); end
    step();
    mem_ack = 1'b0;
    nChecks++; if (mem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC) begin nFails++; $display("FAIL wrap_next got=%h/%h exp=00000000/fffffffc", mem_addr, inst_pc); end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirectPc = '0; mem_ack = 1'b0; inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_delayed_ack();
    test_redirect_discard();
    test_redirect_ack_dequeue();
    test_reset_in_discard();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
